elem_cache_reader: RTL and testbench
====================================

Name: elem_cache_reader

Overview:
- Parametrised successor to the single-element cached SDRAM reader used by the raytracer's scene-data fetch path (triangle and BVH element arrays).
- Fetches fixed-size elements `baseaddr + ELEMBYTES*index` from SDRAM over a 16-bit Avalon-MM master and caches them in a direct-mapped cache with tags and per-line valid bits.
- Uses a valid/ready request/response handshake with back-to-back single-cycle hits and backpressure on responses.
- Adds a flush input and a hit/miss indication.

Parameters:
- NDWORDS, 9, 32-bit words per element.
- ELEMSZ, 32*NDWORDS, element width in bits; ELEMBYTES = ELEMSZ/8.
- IDXW, 32, request index width.
- NLINES, 256, cache lines; power of two, >=2; LW = log2(NLINES).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- baseaddr  in  32  array base byte address; held constant while not idle
- flush  in  1  single-cycle pulse: invalidate all lines
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_index  in  IDXW  element index
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_data  out  ELEMSZ  element data
- rsp_hit  out  1  1 = served from cache, 0 = filled from SDRAM
- avm_m0_read  out  1  Avalon read
- avm_m0_address  out  32  byte address
- avm_m0_readdata  in  16  read data
- avm_m0_readdatavalid  in  1  read data valid
- avm_m0_byteenable  out  2  always 2'b11
- avm_m0_waitrequest  in  1  slave stall

Behaviour:
- **Mapping:** line = index[LW-1:0]; tag = index[IDXW-1:LW]. Data and tag RAMs are synchronous-read. Valid bits are flops.
- **Reset:**
  - All valid bits = 0; state = IDLE.
  - rsp_valid = 0, rsp_hit = 0, rsp_data = 0, avm_m0_read = 0, avm_m0_address = 0, counters = 0.
  - req_ready = 0 while reset is high, 1 on the first cycle after.
- **States:** IDLE, MISS_RD, FILL, RESP.
- **IDLE, lookup pipeline:**
  - Request accepted at cycle T: RAM read and stage-1 capture at T+1.
  - Stage-1 compares tag and valid.
  - On a hit, rsp_valid = 1 and rsp_hit = 1 at T+1 (1-cycle latency).
- **req_ready in IDLE:** req_ready = !flush_pend && (!s1_valid || (s1_hit && rsp_ready)). This gives one hit per cycle when unstalled.
- **Backpressure:** while rsp_valid && !rsp_ready, rsp_data and rsp_hit are held stable and no RAM read is issued.
- **Miss:** stage-1 valid && !hit, so req_ready = 0 and the block goes to MISS_RD next cycle.
- **MISS_RD:**
  - Issues 2*NDWORDS halfword reads, k = 0..2*NDWORDS-1.
  - Address = baseaddr + ELEMBYTES*index + 2*k, mod 2^32.
  - avm_m0_read and address are held while waitrequest is high.
  - Reads are pipelined: k advances each non-stalled cycle.
  - readdatavalid count r stores readdata into bits [16r+15:16r] (little-endian).
  - readdatavalid is ignored in any state other than MISS_RD.
  - Once all issued and r == 2*NDWORDS, go to FILL.
- **FILL (1 cycle):** write data, tag and valid=1 to the line, replacing any previous occupant. Go to RESP.
- **RESP:** rsp_valid = 1, rsp_hit = 0, rsp_data = assembled element. On rsp_ready, go to IDLE and clear stage-1.
- **Flush:**
  - The pulse sets flush_pend at any state.
  - flush_pend is applied in the first IDLE cycle with no stage-1 entry: all valid bits cleared in one cycle, then flush_pend cleared.
  - A flush during a miss is therefore applied after RESP and also invalidates the just-filled line.
  - Flush takes priority over request acceptance.
- **Simultaneous events:**
  - A request accepted in the same cycle a hit response is consumed is legal.
  - A request to the line currently in FILL is not possible, because req_ready = 0 outside IDLE.
- **Reset mid-miss:**
  - avm_m0_read drops the next cycle; partial data is discarded; the line is not validated.
  - Outstanding SDRAM reads must be drained or reset by the system.
- **Tags:** IDXW-LW bits; the full index is compared, so no aliasing.

Test Plan:
- **Cold miss:** baseaddr = 0x1000, NDWORDS = 9, index 3 → 18 reads at 0x106C..0x108E step 2; rsp_hit = 0; data matches memory; line 3 valid.
- **Hit stream:** after the cold miss, index 3 on four consecutive cycles with rsp_ready = 1 → rsp_valid on four consecutive cycles, rsp_hit = 1, no Avalon reads.
- **Conflict:** index 3 then index 3+NLINES (259) → second request misses and refills; index 3 then misses again.
- **Backpressure/stall:**
  - Random waitrequest and rsp_ready = 0 for 5 cycles → address and rsp_data stable; exactly one response per request, in order.
- **Flush:** flush pulse during MISS_RD for index 7 → response delivered (rsp_hit = 0); next index 7 request misses.
- **Reset mid-miss:** assert reset after 4 readdatavalid → avm_m0_read = 0, rsp_valid = 0; a subsequent index 7 request misses and returns correct data.

Source files
------------

// File: rtl/elem_cache_reader.sv
// Direct-mapped element cache in front of a 16-bit Avalon-MM SDRAM master.
// Hits are answered in the cycle after acceptance; misses fetch the element as pipelined halfword reads.
module elem_cache_reader #(
  parameter int NDWORDS = 9,
  parameter int ELEMSZ  = 32 * NDWORDS,
  parameter int IDXW    = 32,
  parameter int NLINES  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       baseaddr,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [IDXW-1:0]   req_index,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ELEMSZ-1:0] rsp_data,
  output logic              rsp_hit,
  output logic              avm_m0_read,
  output logic [31:0]       avm_m0_address,
  input  logic [15:0]       avm_m0_readdata,
  input  logic              avm_m0_readdatavalid,
  output logic [1:0]        avm_m0_byteenable,
  input  logic              avm_m0_waitrequest
);

  localparam int ELEMBYTES = ELEMSZ / 8;
  localparam int LW        = $clog2(NLINES);
  localparam int TW        = IDXW - LW;
  localparam int NRD       = 2 * NDWORDS;
  localparam int CW        = $clog2(NRD + 1);
  localparam logic [CW-1:0] NRD_C  = CW'(NRD);
  localparam logic [CW-1:0] LAST_C = CW'(NRD - 1);

  typedef enum logic [1:0] {IDLE, MISS_RD, FILL, RESP} state_t;

  state_t              state_q;
  logic                s1_valid_q;
  logic [IDXW-1:0]     s1_index_q;
  logic [TW-1:0]       rd_tag_q;
  logic [ELEMSZ-1:0]   rd_data_q;
  logic [ELEMSZ-1:0]   fill_q;
  logic [NLINES-1:0]   line_vld_q;
  logic                flush_pend_q;
  logic                avm_read_q;
  logic [31:0]         avm_addr_q;
  logic [CW-1:0]       issued_q;
  logic [CW-1:0]       rcvd_q;

  logic [ELEMSZ-1:0]   data_mem [NLINES];
  logic [TW-1:0]       tag_mem  [NLINES];

  logic [LW-1:0]       s1_line;
  logic [TW-1:0]       s1_tag;
  logic [LW-1:0]       req_line;
  logic                is_idle;
  logic                s1_hit;
  logic                accept;
  logic                flush_apply;
  logic                rx_take;
  logic [31:0]         idx32;
  logic [31:0]         miss_addr_d;

  assign s1_line  = s1_index_q[LW-1:0];
  assign s1_tag   = s1_index_q[IDXW-1:LW];
  assign req_line = req_index[LW-1:0];
  assign is_idle  = (state_q == IDLE);

  assign s1_hit      = s1_valid_q && line_vld_q[s1_line] && (rd_tag_q == s1_tag);
  assign req_ready   = !reset && is_idle && !flush_pend_q && (!s1_valid_q || (s1_hit && rsp_ready));
  assign accept      = req_valid && req_ready;
  assign flush_apply = is_idle && !s1_valid_q && flush_pend_q;
  assign rx_take     = (state_q == MISS_RD) && avm_m0_readdatavalid && (rcvd_q != NRD_C);

  assign idx32       = 32'(s1_index_q);
  assign miss_addr_d = baseaddr + 32'(ELEMBYTES) * idx32;

  assign rsp_valid = (is_idle && s1_hit) || (state_q == RESP);
  assign rsp_hit   = is_idle && s1_hit;
  assign rsp_data  = (state_q == RESP) ? fill_q : ((is_idle && s1_hit) ? rd_data_q : '0);

  assign avm_m0_read       = avm_read_q;
  assign avm_m0_address    = avm_addr_q;
  assign avm_m0_byteenable = 2'b11;

  // Tag/data RAMs: synchronous read on acceptance, write in FILL
  always_ff @(posedge clk) begin
    if (state_q == FILL) begin
      data_mem[s1_line] <= fill_q;
      tag_mem[s1_line]  <= s1_tag;
    end
    if (accept) begin
      rd_data_q <= data_mem[req_line];
      rd_tag_q  <= tag_mem[req_line];
    end
  end

  // Stage-1 index and halfword assembly buffer carry no reset
  always_ff @(posedge clk) begin
    if (accept) s1_index_q <= req_index;
    if (rx_take) fill_q[{rcvd_q, 4'b0000} +: 16] <= avm_m0_readdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      s1_valid_q   <= 1'b0;
      line_vld_q   <= '0;
      flush_pend_q <= 1'b0;
      avm_read_q   <= 1'b0;
      avm_addr_q   <= '0;
      issued_q     <= '0;
      rcvd_q       <= '0;
    end else begin
      flush_pend_q <= flush || (flush_pend_q && !flush_apply);
      case (state_q)
        IDLE: begin
          if (flush_apply) line_vld_q <= '0;
          if (accept) s1_valid_q <= 1'b1;
          else if (s1_hit && rsp_ready) s1_valid_q <= 1'b0;
          if (s1_valid_q && !s1_hit) begin
            state_q    <= MISS_RD;
            avm_read_q <= 1'b1;
            avm_addr_q <= miss_addr_d;
            issued_q   <= '0;
            rcvd_q     <= '0;
          end
        end
        MISS_RD: begin
          if (avm_read_q && !avm_m0_waitrequest) begin
            issued_q <= issued_q + 1'b1;
            if (issued_q == LAST_C) avm_read_q <= 1'b0;
            else avm_addr_q <= avm_addr_q + 32'd2;
          end
          if (rx_take) rcvd_q <= rcvd_q + 1'b1;
          if (issued_q == NRD_C && rcvd_q == NRD_C) state_q <= FILL;
        end
        FILL: begin
          line_vld_q[s1_line] <= 1'b1;
          state_q             <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            state_q    <= IDLE;
            s1_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_elem_cache_reader.sv
// Scoreboard bench for elem_cache_reader: random traffic against a behavioural cache model
// and a randomly stalling Avalon slave backed by a hashed memory image.
module tb_elem_cache_reader;

  localparam int NDW = 9;
  localparam int ESZ = 32 * NDW;
  localparam int NL  = 256;
  localparam int NRD = 2 * NDW;

  logic           clk;
  logic           reset;
  logic [31:0]    baseaddr;
  logic           flush;
  logic           req_valid;
  logic           req_ready;
  logic [31:0]    req_index;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [ESZ-1:0] rsp_data;
  logic           rsp_hit;
  logic           avm_read;
  logic [31:0]    avm_addr;
  logic [15:0]    avm_rdata;
  logic           avm_rdv;
  logic [1:0]     avm_be;
  logic           avm_wait;

  elem_cache_reader #(.NDWORDS(NDW), .ELEMSZ(ESZ), .IDXW(32), .NLINES(NL)) dut (
    .clk(clk), .reset(reset), .baseaddr(baseaddr), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_hit(rsp_hit),
    .avm_m0_read(avm_read), .avm_m0_address(avm_addr), .avm_m0_readdata(avm_rdata),
    .avm_m0_readdatavalid(avm_rdv), .avm_m0_byteenable(avm_be), .avm_m0_waitrequest(avm_wait)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [ESZ-1:0] data;
    logic           hit;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] pend_q[$];
  bit          mvld [NL];
  logic [23:0] mtag [NL];

  int checks = 0;
  int errors = 0;
  int rr_mode = 0;
  int wr_mode = 0;
  int rdv_cnt = 0;
  bit held = 0;
  logic [ESZ-1:0] hdata;
  logic           hhit;

  function automatic logic [15:0] mem_hw(input logic [31:0] a);
    logic [31:0] t;
    t = a * 32'h9E3779B1;
    return t[31:16] ^ a[15:0];
  endfunction

  function automatic logic [ESZ-1:0] elem(input logic [31:0] base, input logic [31:0] idx);
    logic [ESZ-1:0] e;
    e = '0;
    for (int k = 0; k < NRD; k++) e[16*k +: 16] = mem_hw(base + 32'd36 * idx + 32'(2 * k));
    return e;
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkw(input string name, input logic [ESZ-1:0] act, input logic [ESZ-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not observed within bound", name);
  endtask

  task automatic model_clear();
    for (int i = 0; i < NL; i++) mvld[i] = 1'b0;
  endtask

  task automatic model_accept(input logic [31:0] idx);
    exp_t e;
    logic [7:0]  line;
    logic [23:0] tag;
    line = idx[7:0];
    tag  = idx[31:8];
    e.hit  = mvld[line] && (mtag[line] == tag);
    e.data = elem(baseaddr, idx);
    exp_q.push_back(e);
    if (!e.hit) begin
      for (int k = 0; k < NRD; k++) addr_q.push_back(baseaddr + 32'd36 * idx + 32'(2 * k));
      mvld[line] = 1'b1;
      mtag[line] = tag;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic send(input logic [31:0] idx, output int waited);
    bit done;
    @(negedge clk);
    req_valid = 1'b1;
    req_index = idx;
    flush = 1'b0;
    done = 1'b0;
    waited = 0;
    for (int n = 0; n < 400 && !done; n++) begin
      #4;
      if (req_ready) begin
        model_accept(idx);
        done = 1'b1;
        @(posedge clk);
      end else begin
        waited++;
        @(negedge clk);
      end
    end
    if (!done) begin
      fail_event("req_accept");
      req_valid = 1'b0;
    end
  endtask

  task automatic pulse_flush();
    @(negedge clk);
    req_valid = 1'b0;
    flush = 1'b1;
    model_clear();
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 4000 && !done; n++) begin
      idle();
      #4;
      if (exp_q.size() == 0 && addr_q.size() == 0 && pend_q.size() == 0 && !held) done = 1'b1;
    end
    if (!done) fail_event("drain");
  endtask

  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rr_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = ($urandom_range(0, 9) < 7);
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  // Avalon slave: random stalls, in-order read data with random latency
  initial begin
    bit          prev_stall;
    logic [31:0] prev_addr;
    prev_stall = 1'b0;
    prev_addr  = '0;
    avm_wait   = 1'b0;
    avm_rdv    = 1'b0;
    avm_rdata  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend_q.delete();
        avm_rdv = 1'b0;
      end else if (pend_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        avm_rdv   = 1'b1;
        avm_rdata = mem_hw(pend_q.pop_front());
      end else begin
        avm_rdv = 1'b0;
      end
      avm_wait = (wr_mode != 0) && ($urandom_range(0, 9) < 4);
      #4;
      if (!reset) begin
        if (prev_stall) begin
          check1("avm_hold_read", avm_read, 1'b1);
          check32("avm_hold_addr", avm_addr, prev_addr);
        end
        if (avm_rdv) rdv_cnt++;
        if (avm_read && !avm_wait) begin
          if (addr_q.size() == 0) fail_event("avm_read_expected");
          else check32("avm_addr", avm_addr, addr_q.pop_front());
          pend_q.push_back(avm_addr);
        end
        prev_stall = avm_read && avm_wait;
        prev_addr  = avm_addr;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // Response monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (reset) begin
        held = 1'b0;
      end else if (rsp_valid) begin
        if (held) begin
          checkw("rsp_hold_data", rsp_data, hdata);
          check1("rsp_hold_hit", rsp_hit, hhit);
        end
        if (rsp_ready) begin
          if (exp_q.size() == 0) fail_event("rsp_expected");
          else begin
            e = exp_q.pop_front();
            checkw("rsp_data", rsp_data, e.data);
            check1("rsp_hit", rsp_hit, e.hit);
          end
          held = 1'b0;
        end else begin
          held  = 1'b1;
          hdata = rsp_data;
          hhit  = rsp_hit;
        end
      end else begin
        if (held) fail_event("rsp_valid_held");
        held = 1'b0;
      end
    end
  end

  initial begin
    int w;
    bit seen;
    logic [31:0] idx;
    reset     = 1'b1;
    flush     = 1'b0;
    req_valid = 1'b0;
    req_index = '0;
    baseaddr  = 32'h0000_1000;
    model_clear();

    repeat (2) @(negedge clk);
    #4;
    check1("reset_req_ready", req_ready, 1'b0);
    check1("reset_rsp_valid", rsp_valid, 1'b0);
    check1("reset_rsp_hit", rsp_hit, 1'b0);
    checkw("reset_rsp_data", rsp_data, '0);
    check1("reset_avm_read", avm_read, 1'b0);
    check32("reset_avm_addr", avm_addr, 32'h0);
    check32("byteenable", {30'd0, avm_be}, 32'd3);
    @(negedge clk);
    reset = 1'b0;
    #4;
    check1("ready_after_reset", req_ready, 1'b1);

    // cold miss on index 3, then a four-deep hit stream
    send(32'd3, w);
    drain();
    for (int i = 0; i < 4; i++) begin
      send(32'd3, w);
      check32("hit_stream_no_stall", 32'(w), 32'd0);
    end
    drain();

    // conflict on line 3
    send(32'd3, w);
    send(32'd259, w);
    send(32'd3, w);
    drain();

    // random traffic with stalls, backpressure and flushes
    rr_mode = 1;
    wr_mode = 1;
    for (int i = 0; i < 70; i++) begin
      idx = 32'($urandom_range(0, 5)) + 32'd256 * 32'($urandom_range(0, 2));
      case ($urandom_range(0, 9))
        0: pulse_flush();
        1: idle();
        2: begin
          send(idx, w);
          rr_mode = 2;
          repeat (5) idle();
          rr_mode = 1;
        end
        default: send(idx, w);
      endcase
    end
    drain();

    // flush while index 7 is being fetched
    send(32'd7, w);
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      idle();
      #4;
      if (avm_read) seen = 1'b1;
    end
    if (!seen) fail_event("miss_read_start");
    pulse_flush();
    drain();
    send(32'd7, w);
    drain();

    // reset in the middle of a miss
    rdv_cnt = 0;
    send(32'd263, w);
    seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      idle();
      #4;
      if (rdv_cnt >= 4) seen = 1'b1;
    end
    if (!seen) fail_event("partial_fill");
    @(negedge clk);
    reset     = 1'b1;
    req_valid = 1'b0;
    flush     = 1'b0;
    model_clear();
    addr_q.delete();
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    @(negedge clk);
    #4;
    check1("midmiss_avm_read", avm_read, 1'b0);
    check1("midmiss_rsp_valid", rsp_valid, 1'b0);
    check1("midmiss_req_ready", req_ready, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    send(32'd7, w);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
